// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the IF/ID register payload type.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          RS_MSB    = 25;
  localparam int          RS_LSB    = 21;
  localparam int          RT_MSB    = 20;
  localparam int          RT_LSB    = 16;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/decode controls in, imem address and IF/ID contents out.
interface fetch_stage_if #(
  parameter int CNT_W = 32
);

  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc4;
  logic             ifid_valid;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, ifid_rs, ifid_rt,
           stall_count, flush_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, ifid_rs, ifid_rt,
           stall_count, flush_count
  );

endinterface

// File: rtl/fetch_stage_ifid_register.sv
// IF/ID pipeline register; clear (flush to bubble) wins over hold (stall).
module ifid_register
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_hold,
  input  logic  i_clear,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};
    end else if (i_clear) begin
      r_q <= '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: program counter, IF/ID load with stall/flush, and event counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [31:0]      w_pc4;
  ifid_t            w_ifid_d;
  ifid_t            w_ifid_q;

  assign w_pc4    = r_pc + PC_INC;
  assign w_ifid_d = '{instr: bus.imem_data, pc4: w_pc4, valid: 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc <= bus.redirect_pc;
    end else if (!bus.stall) begin
      r_pc <= w_pc4;
    end
  end

  // A stall that coincides with a redirect is not a stall cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.redirect) begin
      r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end else if (bus.stall) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  ifid_register u_ifid (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (bus.stall),
    .i_clear (bus.redirect),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign bus.imem_addr   = r_pc;
  assign bus.ifid_instr  = w_ifid_q.instr;
  assign bus.ifid_pc4    = w_ifid_q.pc4;
  assign bus.ifid_valid  = w_ifid_q.valid;
  assign bus.ifid_rs     = w_ifid_q.instr[RS_MSB:RS_LSB];
  assign bus.ifid_rt     = w_ifid_q.instr[RT_MSB:RT_LSB];
  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed and random stall/redirect traffic against a pipeline model.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.CNT_W(32)) bus_a ();
  fetch_stage_if #(.CNT_W(32)) bus_b ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk (clk), .rst (rst), .bus (bus_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut_wrap (
    .clk (clk), .rst (rst2), .bus (bus_b)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus_a.imem_data = mem_word(bus_a.imem_addr);
  assign bus_b.imem_data = mem_word(bus_b.imem_addr);

  // Reference pipeline state
  logic [31:0] m_pc, m_instr, m_pc4, m_stall_cnt, m_flush_cnt;
  logic        m_valid;

  task automatic model_reset();
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    m_stall_cnt = 32'd0; m_flush_cnt = 32'd0;
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] rpc);
    if (rd) begin
      m_pc = rpc; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      m_flush_cnt = m_flush_cnt + 1;
    end else if (st) begin
      m_stall_cnt = m_stall_cnt + 1;
    end else begin
      m_instr = mem_word(m_pc);
      m_pc    = m_pc + 4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  bus_a.imem_addr, m_pc);
    chk({tag, ".instr"}, bus_a.ifid_instr, m_instr);
    chk({tag, ".pc4"},   bus_a.ifid_pc4, m_pc4);
    chk({tag, ".valid"}, {31'd0, bus_a.ifid_valid}, {31'd0, m_valid});
    chk({tag, ".rs"},    {27'd0, bus_a.ifid_rs}, (m_instr >> 21) & 32'h1F);
    chk({tag, ".rt"},    {27'd0, bus_a.ifid_rt}, (m_instr >> 16) & 32'h1F);
    chk({tag, ".scnt"},  bus_a.stall_count, m_stall_cnt);
    chk({tag, ".fcnt"},  bus_a.flush_count, m_flush_cnt);
  endtask

  // Inputs are set on the falling edge; one rising edge is taken and checked 1 time unit later.
  task automatic cycle(input string tag);
    logic        st, rd;
    logic [31:0] rpc;
    @(posedge clk);
    st = bus_a.stall; rd = bus_a.redirect; rpc = bus_a.redirect_pc;
    model_edge(st, rd, rpc);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    bus_a.stall = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_pc = 32'd0;
    bus_b.stall = 1'b0; bus_b.redirect = 1'b0; bus_b.redirect_pc = 32'd0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    cycle("first");
    chk("first.instr_k", bus_a.ifid_instr, 32'h8C22_0004);
    chk("first.rs_k",    {27'd0, bus_a.ifid_rs}, 32'd1);
    chk("first.rt_k",    {27'd0, bus_a.ifid_rt}, 32'd2);
    chk("first.pc4_k",   bus_a.ifid_pc4, 32'd4);
    chk("first.addr_k",  bus_a.imem_addr, 32'd4);

    cycle("second");
    bus_a.stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle("stall");
    chk("stall.addr_k", bus_a.imem_addr, 32'd8);
    chk("stall.cnt_k",  bus_a.stall_count, 32'd3);
    chk("stall.pc4_k",  bus_a.ifid_pc4, 32'd8);
    bus_a.stall = 1'b0;
    cycle("unstall");
    chk("unstall.addr_k", bus_a.imem_addr, 32'd12);

    bus_a.redirect = 1'b1; bus_a.redirect_pc = 32'h0000_0100;
    cycle("redir");
    chk("redir.valid_k", {31'd0, bus_a.ifid_valid}, 32'd0);
    chk("redir.instr_k", bus_a.ifid_instr, 32'd0);
    chk("redir.addr_k",  bus_a.imem_addr, 32'h100);
    chk("redir.fcnt_k",  bus_a.flush_count, 32'd1);
    bus_a.redirect = 1'b0;
    cycle("redir2");
    chk("redir2.pc4_k",   bus_a.ifid_pc4, 32'h104);
    chk("redir2.valid_k", {31'd0, bus_a.ifid_valid}, 32'd1);
    chk("redir2.instr_k", bus_a.ifid_instr, mem_word(32'h100));

    bus_a.stall = 1'b1; bus_a.redirect = 1'b1; bus_a.redirect_pc = 32'h0000_2000;
    cycle("both");
    chk("both.scnt_k", bus_a.stall_count, 32'd3);
    chk("both.fcnt_k", bus_a.flush_count, 32'd2);
    chk("both.addr_k", bus_a.imem_addr, 32'h2000);
    bus_a.stall = 1'b0; bus_a.redirect = 1'b0;

    for (int i = 0; i < 300; i++) begin
      bus_a.stall       = ($urandom % 4) == 0;
      bus_a.redirect    = ($urandom % 7) == 0;
      bus_a.redirect_pc = $urandom & 32'hFFFF_FFFC;
      cycle("rand");
    end

    // Asynchronous reset in the middle of a stall with non-zero counters
    bus_a.redirect = 1'b0; bus_a.stall = 1'b1;
    cycle("prerst");
    cycle("prerst");
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.scnt_k", bus_a.stall_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_a.stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_a.stall       = ($urandom % 3) == 0;
      bus_a.redirect    = ($urandom % 5) == 0;
      bus_a.redirect_pc = $urandom & 32'hFFFF_FFFC;
      cycle("post");
    end

    // PC wrap from a reset vector at the top of the address space
    chk("wrap.reset_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    @(posedge clk); #1;
    chk("wrap.addr1",  bus_b.imem_addr, 32'd0);
    chk("wrap.pc4_1",  bus_b.ifid_pc4, 32'd0);
    chk("wrap.instr1", bus_b.ifid_instr, mem_word(32'hFFFF_FFFC));
    chk("wrap.valid1", {31'd0, bus_b.ifid_valid}, 32'd1);
    @(posedge clk); #1;
    chk("wrap.addr2",  bus_b.imem_addr, 32'd4);
    chk("wrap.pc4_2",  bus_b.ifid_pc4, 32'd4);
    chk("wrap.instr2", bus_b.ifid_instr, 32'h8C22_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
